mmcm_div_ctrl: RTL and testbench

Request sequencer that sits directly upstream of the `xilinx7_reconfig` DRP engine. It accepts integer divide requests for CLKOUT0 and CLKFBOUT through a valid/ready handshake and range-checks them. It encodes each divide into the HIGH_TIME/LOW_TIME/EDGE/NO_COUNT counter fields, then drives the engine's `ready`/`start_reconfig`/`reconfig_done` handshake. Completion is reported only after the MMCM has re-locked stably, so top-level sweep logic does not hand-code half-periods or pulse timing.

---
 rtl/mmcm_div_pkg.sv | 41 ++++
 rtl/mmcm_div_encode.sv | 11 +
 rtl/mmcm_div_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mmcm_div_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_div_pkg.sv
// Shared types for the MMCM divide request sequencer: FSM states, field widths,
// and the divide-to-counter-field encoding.
package mmcm_div_pkg;

  localparam int DIV_W  = 7;
  localparam int TIME_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_READY,
    ST_START,
    ST_WAIT_DONE,
    ST_WAIT_LOCK
  } state_t;

  typedef struct packed {
    logic [TIME_W-1:0] high_time;
    logic [TIME_W-1:0] low_time;
    logic              edge_bit;
    logic              no_count;
  } div_fields_t;

  // Divide-by-1 bypasses the counter, so it gets a fixed 1/1 encoding.
  function automatic div_fields_t encode_div(input logic [DIV_W-1:0] d);
    div_fields_t f;
    if (d == DIV_W'(1)) begin
      f.high_time = TIME_W'(1);
      f.low_time  = TIME_W'(1);
      f.edge_bit  = 1'b0;
      f.no_count  = 1'b1;
    end else begin
      f.high_time = d[DIV_W-1:1];
      f.low_time  = TIME_W'(d - {1'b0, d[DIV_W-1:1]});
      f.edge_bit  = d[0];
      f.no_count  = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/mmcm_div_encode.sv
// Combinational divide-to-field encoder for one MMCM counter.
module mmcm_div_encode
  import mmcm_div_pkg::*;
(
  input  logic [DIV_W-1:0] div,
  output div_fields_t      fields
);

  assign fields = encode_div(div);

endmodule

// File: rtl/mmcm_div_ctrl.sv
// Divide request sequencer in front of the DRP reconfig engine.
// Optional lock timeout enabled by defining MMCM_DIV_CTRL_LOCK_TIMEOUT_EN.
module mmcm_div_ctrl
  import mmcm_div_pkg::*;
#(
  parameter int DIV_MAX      = 126,
  parameter int DEF_DIV_OUT0 = 20,
  parameter int DEF_DIV_FB   = 20,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIV_W-1:0]  req_div_out0,
  input  logic [DIV_W-1:0]  req_div_fb,
  input  logic              reconfig_ready,
  input  logic              reconfig_done,
  input  logic              mmcm_locked,
  output logic              start_reconfig,
  output logic [TIME_W-1:0] clkout0_high_time,
  output logic [TIME_W-1:0] clkout0_low_time,
  output logic              clkout0_edge,
  output logic              clkout0_no_count,
  output logic [TIME_W-1:0] clkfbout_high_time,
  output logic [TIME_W-1:0] clkfbout_low_time,
  output logic              clkfbout_edge,
  output logic              clkfbout_no_count,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_lock
);

  localparam logic [DIV_W-1:0] DIV_MAX_V = DIV_W'(DIV_MAX);
  localparam div_fields_t      DEF_OUT0  = encode_div(DIV_W'(DEF_DIV_OUT0));
  localparam div_fields_t      DEF_FB    = encode_div(DIV_W'(DEF_DIV_FB));
  localparam int               CNT_W     = $clog2(LOCK_STABLE + 1);
  localparam logic [CNT_W-1:0] STABLE_V  = CNT_W'(LOCK_STABLE);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_out0_q, div_out0_d, div_fb_q, div_fb_d;
  div_fields_t       out0_q, out0_d, fb_q, fb_d;
  div_fields_t       enc_out0, enc_fb;
  logic [CNT_W-1:0]  stable_q, stable_d, stable_inc;
  logic              req_ready_q, req_ready_d, busy_q, busy_d;
  logic              start_q, start_d, done_q, done_d, err_range_q, err_range_d;
  logic              in_range;
`ifdef MMCM_DIV_CTRL_LOCK_TIMEOUT_EN
  logic [15:0]       tmo_q, tmo_d;
  logic              err_lock_q, err_lock_d;
`endif

  mmcm_div_encode u_enc_out0 (.div(div_out0_q), .fields(enc_out0));
  mmcm_div_encode u_enc_fb   (.div(div_fb_q),   .fields(enc_fb));

  assign in_range   = (div_out0_q != '0) && (div_out0_q <= DIV_MAX_V) &&
                      (div_fb_q   != '0) && (div_fb_q   <= DIV_MAX_V);
  assign stable_inc = stable_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    div_out0_d  = div_out0_q;
    div_fb_d    = div_fb_q;
    out0_d      = out0_q;
    fb_d        = fb_q;
    stable_d    = stable_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    err_range_d = 1'b0;
`ifdef MMCM_DIV_CTRL_LOCK_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_lock_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          div_out0_d = req_div_out0;
          div_fb_d   = req_div_fb;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (in_range) begin
          out0_d  = enc_out0;
          fb_d    = enc_fb;
          state_d = ST_WAIT_READY;
        end else begin
          err_range_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT_READY: begin
        if (reconfig_ready) begin
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // A lock already high here is stale; counting begins in WAIT_LOCK.
        if (reconfig_done) begin
          stable_d = '0;
`ifdef MMCM_DIV_CTRL_LOCK_TIMEOUT_EN
          tmo_d    = '0;
`endif
          state_d  = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        stable_d = mmcm_locked ? stable_inc : '0;
        if (mmcm_locked && (stable_inc == STABLE_V)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef MMCM_DIV_CTRL_LOCK_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == 16'(LOCK_TIMEOUT)) begin
            err_lock_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_out0_q  <= DIV_W'(DEF_DIV_OUT0);
      div_fb_q    <= DIV_W'(DEF_DIV_FB);
      out0_q      <= DEF_OUT0;
      fb_q        <= DEF_FB;
      stable_q    <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_range_q <= 1'b0;
`ifdef MMCM_DIV_CTRL_LOCK_TIMEOUT_EN
      tmo_q       <= '0;
      err_lock_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_out0_q  <= div_out0_d;
      div_fb_q    <= div_fb_d;
      out0_q      <= out0_d;
      fb_q        <= fb_d;
      stable_q    <= stable_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_range_q <= err_range_d;
`ifdef MMCM_DIV_CTRL_LOCK_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_lock_q  <= err_lock_d;
`endif
    end
  end

`ifdef MMCM_DIV_CTRL_LOCK_TIMEOUT_EN
  assign err_lock = err_lock_q;
`else
  // Constant low; the term keeps LOCK_TIMEOUT referenced when the timeout is compiled out.
  assign err_lock = (LOCK_TIMEOUT < 0);
`endif

  assign req_ready          = req_ready_q;
  assign busy               = busy_q;
  assign start_reconfig     = start_q;
  assign done               = done_q;
  assign err_range          = err_range_q;
  assign clkout0_high_time  = out0_q.high_time;
  assign clkout0_low_time   = out0_q.low_time;
  assign clkout0_edge       = out0_q.edge_bit;
  assign clkout0_no_count   = out0_q.no_count;
  assign clkfbout_high_time = fb_q.high_time;
  assign clkfbout_low_time  = fb_q.low_time;
  assign clkfbout_edge      = fb_q.edge_bit;
  assign clkfbout_no_count  = fb_q.no_count;

endmodule

// File: tb/tb_mmcm_div_ctrl.sv
// Scoreboard bench for mmcm_div_ctrl: the driver queues expected pulses with
// their cycle and field values, a negedge monitor pops and compares them.
module tb_mmcm_div_ctrl;

  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 100;

  localparam logic [3:0] K_START = 4'b0001;
  localparam logic [3:0] K_DONE  = 4'b0010;
  localparam logic [3:0] K_ERR   = 4'b0100;
  localparam logic [3:0] K_LOCK  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [6:0] req_div_out0 = '0;
  logic [6:0] req_div_fb = '0;
  logic       reconfig_ready = 1'b0;
  logic       reconfig_done = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic       req_ready, start_reconfig, busy, done, err_range, err_lock;
  logic [5:0] clkout0_high_time, clkout0_low_time, clkfbout_high_time, clkfbout_low_time;
  logic       clkout0_edge, clkout0_no_count, clkfbout_edge, clkfbout_no_count;

  mmcm_div_ctrl #(
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_div_out0(req_div_out0), .req_div_fb(req_div_fb),
    .reconfig_ready(reconfig_ready), .reconfig_done(reconfig_done),
    .mmcm_locked(mmcm_locked), .start_reconfig(start_reconfig),
    .clkout0_high_time(clkout0_high_time), .clkout0_low_time(clkout0_low_time),
    .clkout0_edge(clkout0_edge), .clkout0_no_count(clkout0_no_count),
    .clkfbout_high_time(clkfbout_high_time), .clkfbout_low_time(clkfbout_low_time),
    .clkfbout_edge(clkfbout_edge), .clkfbout_no_count(clkfbout_no_count),
    .busy(busy), .done(done), .err_range(err_range), .err_lock(err_lock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  kind;
    int          cyc;
    logic [13:0] f0;
    logic [13:0] fb;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [13:0] cur_f0, cur_fb;

  function automatic logic [13:0] fld(input int h, input int l, input int e, input int n);
    return {6'(h), 6'(l), 1'(e), 1'(n)};
  endfunction

  function automatic logic [13:0] act_f0();
    return {clkout0_high_time, clkout0_low_time, clkout0_edge, clkout0_no_count};
  endfunction

  function automatic logic [13:0] act_fb();
    return {clkfbout_high_time, clkfbout_low_time, clkfbout_edge, clkfbout_no_count};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: each output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_pulse: kind %b expected at cycle %0d, now %0d", sb[0].kind, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if ({err_lock, err_range, done, start_reconfig} != 4'b0000) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: got kind %b at cycle %0d, expected none",
                   {err_lock, err_range, done, start_reconfig}, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_kind", {28'd0, err_lock, err_range, done, start_reconfig}, {28'd0, e.kind});
          check("pulse_cycle", cyc, e.cyc);
          check("clkout0_fields", {18'd0, act_f0()}, {18'd0, e.f0});
          check("clkfbout_fields", {18'd0, act_fb()}, {18'd0, e.fb});
          check("req_ready_at_pulse", {31'd0, req_ready}, {31'd0, e.kind != K_START});
          check("busy_at_pulse", {31'd0, busy}, {31'd0, e.kind == K_START});
          $display("txn kind=%b cycle=%0d f0=%h fb=%h", e.kind, cyc, act_f0(), act_fb());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic [3:0] k, input int c, input logic [13:0] f0, input logic [13:0] fb);
    exp_t e;
    e.kind = k; e.cyc = c; e.f0 = f0; e.fb = fb;
    sb.push_back(e);
  endtask

  // Present a request until accepted; returns the cycle in which it was accepted.
  task automatic issue(input int o0, input int fb, output int a);
    int k;
    k = 0;
    while (!req_ready && k < 200) begin
      tick();
      k++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
    end
    req_valid    = 1'b1;
    req_div_out0 = 7'(o0);
    req_div_fb   = 7'(fb);
    a = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  // Full reconfiguration; lock rises lock_gap cycles after the reconfig_done cycle,
  // optionally dropping for one cycle glitch_off cycles into the counted window.
  task automatic run(input int o0, input int fb, input logic [13:0] ef0, input logic [13:0] efb,
                     input int rdy_low, input int lock_gap, input int glitch_off);
    int a, s, l, cs, dn;
    if (rdy_low > 0) reconfig_ready = 1'b0;
    issue(o0, fb, a);
    check("fields_hold_in_check", {18'd0, act_f0()}, {18'd0, cur_f0});
    tick();
    check("clkout0_update", {18'd0, act_f0()}, {18'd0, ef0});
    check("clkfbout_update", {18'd0, act_fb()}, {18'd0, efb});
    if (rdy_low > 0) begin
      goto(a + 2 + rdy_low);
      reconfig_ready = 1'b1;
    end
    s = cyc + 1;
    push(K_START, s, ef0, efb);
    l = s + 2 + lock_gap;
    if (l <= s + 2) begin
      goto(l);
      mmcm_locked = 1'b1;
    end
    goto(s + 2);
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    if (l > s + 2) begin
      goto(l);
      mmcm_locked = 1'b1;
    end
    cs = (l > s + 3) ? l : s + 3;
    dn = cs + LOCK_STABLE;
    if (glitch_off >= 0) begin
      goto(cs + glitch_off);
      mmcm_locked = 1'b0;
      tick();
      mmcm_locked = 1'b1;
      dn = cyc + LOCK_STABLE;
    end
    push(K_DONE, dn, ef0, efb);
    goto(dn);
    tick();
    mmcm_locked = 1'b0;
    cur_f0 = ef0;
    cur_fb = efb;
  endtask

  task automatic reject(input int o0, input int fb);
    int a;
    issue(o0, fb, a);
    push(K_ERR, a + 2, cur_f0, cur_fb);
    goto(a + 6);
    check("fields_after_reject_out0", {18'd0, act_f0()}, {18'd0, cur_f0});
    check("fields_after_reject_fb", {18'd0, act_fb()}, {18'd0, cur_fb});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, s;
    logic [13:0] f20;
    f20 = fld(10, 10, 0, 0);
    cur_f0 = f20;
    cur_fb = f20;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {28'd0, err_lock, err_range, done, start_reconfig}, 32'd0);
    check("rst_clkout0", {18'd0, act_f0()}, {18'd0, f20});
    check("rst_clkfbout", {18'd0, act_fb()}, {18'd0, f20});
    rst = 1'b0;
    repeat (3) tick();
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("idle_clkout0", {18'd0, act_f0()}, {18'd0, f20});

    reconfig_ready = 1'b1;
    run(21, 20, fld(10, 11, 1, 0), f20, 0, 5, -1);
    run(1, 20, fld(1, 1, 0, 1), f20, 0, 0, -1);
    reject(0, 20);
    reject(21, 127);
    reject(127, 5);
    run(126, 126, fld(63, 63, 0, 0), fld(63, 63, 0, 0), 50, -1, -1);
    run(9, 7, fld(4, 5, 1, 0), fld(3, 4, 1, 0), 0, 1, 4);

    // Reset while waiting for the engine to finish.
    issue(50, 30, a);
    s = a + 3;
    push(K_START, s, fld(25, 25, 0, 0), fld(15, 15, 0, 0));
    goto(s + 3);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_start", {31'd0, start_reconfig}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_clkout0", {18'd0, act_f0()}, {18'd0, f20});
    check("midrst_clkfbout", {18'd0, act_fb()}, {18'd0, f20});
    tick();
    rst = 1'b0;
    cur_f0 = f20;
    cur_fb = f20;
    tick();
    run(126, 1, fld(63, 63, 0, 0), fld(1, 1, 0, 1), 0, 3, -1);

`ifdef MMCM_DIV_CTRL_LOCK_TIMEOUT_EN
    issue(22, 24, a);
    s = a + 3;
    push(K_START, s, fld(11, 11, 0, 0), fld(12, 12, 0, 0));
    goto(s + 2);
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    push(K_LOCK, s + 3 + LOCK_TIMEOUT, fld(11, 11, 0, 0), fld(12, 12, 0, 0));
    goto(s + 3 + LOCK_TIMEOUT + 4);
    check("timeout_req_ready", {31'd0, req_ready}, 32'd1);
`endif

    goto(cyc + 5);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
